// File: rtl/shift_reg_arbiter.sv
// shift_reg_arbiter: round-robin sharing of one shift_reg delay line with an owner-tag pipe and flush sequencer
module shift_reg_arbiter #(
    parameter int Width  = 8,
    parameter int Size   = 3,
    parameter int NumReq = 2,
    localparam int IdW   = $clog2(NumReq),
    localparam int OccW  = $clog2(Size + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NumReq-1:0]       req_valid_i,
    input  logic [NumReq*Width-1:0] req_data_i,
    output logic [NumReq-1:0]       req_ready_o,
    input  logic                    flush_i,
    output logic                    sr_we_o,
    output logic [Width-1:0]        sr_data_o,
    input  logic [Width-1:0]        sr_data_i,
    output logic                    out_valid_o,
    output logic [IdW-1:0]          out_id_o,
    output logic [Width-1:0]        out_data_o,
    output logic [OccW-1:0]         occ_o,
    output logic                    flush_done_o
);
    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;
    logic [0:0]      state;
    logic [IdW-1:0]  rr_ptr, gnt_id;
    logic            gnt_found, transfer;
    logic [Size-1:0] tv_q, tv_n;
    logic [IdW-1:0]  tid_q [Size];
    logic [IdW-1:0]  tid_n [Size];
    logic [OccW-1:0] occ_n;
    // first valid requester at or after the round-robin pointer
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int k = 0; k < NumReq; k++)
            if (!gnt_found && req_valid_i[(int'(rr_ptr) + k) % NumReq]) begin
                gnt_found = 1'b1;
                gnt_id    = IdW'((int'(rr_ptr) + k) % NumReq);
            end
    end
    // outputs are gated by rst_ni so they read 0 while reset is held
    assign transfer     = rst_ni && state == RUN && !flush_i && gnt_found;
    assign req_ready_o  = transfer ? NumReq'(1) << gnt_id : '0;
    assign sr_we_o      = rst_ni && (state == FLUSH || transfer);
    assign sr_data_o    = transfer ? req_data_i[gnt_id*Width +: Width] : '0;
    assign out_data_o   = sr_data_i;
    assign out_id_o     = tid_q[Size-1];
    // tag pipe mirrors the delay line; bubbles carry valid=0, id=0
    always_comb begin
        tv_n  = tv_q;
        tid_n = tid_q;
        occ_n = '0;
        if (sr_we_o) begin
            tv_n[0]  = transfer;
            tid_n[0] = transfer ? gnt_id : '0;
            for (int k = 1; k < Size; k++) begin
                tv_n[k]  = tv_q[k-1];
                tid_n[k] = tid_q[k-1];
            end
        end
        for (int k = 0; k < Size; k++)
            occ_n = occ_n + OccW'(tv_n[k]);
    end
    // state, pointer, tag pipe and pulse registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= RUN;
            rr_ptr       <= '0;
            tv_q         <= '0;
            tid_q        <= '{default: '0};
            occ_o        <= '0;
            out_valid_o  <= 1'b0;
            flush_done_o <= 1'b0;
        end else begin
            tv_q         <= tv_n;
            tid_q        <= tid_n;
            occ_o        <= occ_n;
            out_valid_o  <= sr_we_o && tv_n[Size-1];
            flush_done_o <= 1'b0;
            if (transfer)
                rr_ptr <= gnt_id == IdW'(NumReq - 1) ? '0 : gnt_id + 1'b1;
            if (state == RUN && flush_i) begin
                if (occ_o == '0) flush_done_o <= 1'b1;
                else             state        <= FLUSH;
            end else if (state == FLUSH && occ_n == '0) begin
                state        <= RUN;
                flush_done_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_shift_reg_arbiter.sv
// tb_shift_reg_arbiter: directed vector table plus hand sequences for flush and reset corners
module tb_shift_reg_arbiter;
    localparam int W = 8;
    localparam int S = 3;
    localparam int N = 2;
    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic [N-1:0]   req_valid_i = '0;
    logic [N*W-1:0] req_data_i = '0;
    logic [N-1:0]   req_ready_o;
    logic           flush_i = 1'b0;
    logic           sr_we_o;
    logic [W-1:0]   sr_data_o, sr_data_i, out_data_o;
    logic           out_valid_o, flush_done_o;
    logic [0:0]     out_id_o;
    logic [1:0]     occ_o;
    logic [W-1:0]   sr_q [S];
    int n_tests = 0;
    int n_fail  = 0;
    typedef struct {
        logic [1:0] valid;
        logic [7:0] d0, d1;
        logic       fl;
        logic [1:0] rdy;
        logic       we;
        logic [7:0] sd;
        logic       ov;
        logic       oid;
        logic [7:0] od;
        logic [1:0] occ;
        logic       fd;
    } vec_t;
    vec_t vecs [10];
    shift_reg_arbiter #(.Width(W), .Size(S), .NumReq(N)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
        .req_ready_o(req_ready_o), .flush_i(flush_i), .sr_we_o(sr_we_o), .sr_data_o(sr_data_o),
        .sr_data_i(sr_data_i), .out_valid_o(out_valid_o), .out_id_o(out_id_o),
        .out_data_o(out_data_o), .occ_o(occ_o), .flush_done_o(flush_done_o)
    );
    always #5 clk_i = ~clk_i;
    // behavioural shift_reg the arbiter drives
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < S; k++) sr_q[k] <= '0;
        end else if (sr_we_o) begin
            sr_q[0] <= sr_data_o;
            for (int k = 1; k < S; k++) sr_q[k] <= sr_q[k-1];
        end
    end
    assign sr_data_i = sr_q[S-1];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask
    task automatic do_reset();
        rst_ni = 1'b0;
        req_valid_i = '0;
        flush_i = 1'b0;
        tick();
        rst_ni = 1'b1;
    endtask
    task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1, input logic fl);
        req_valid_i = v;
        req_data_i  = {d1, d0};
        flush_i     = fl;
    endtask
    initial begin
        //          valid  d0     d1     fl    rdy    we    sd     ov    oid   od     occ   fd
        vecs[0] = '{2'b11, 8'h11, 8'h22, 1'b0, 2'b01, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 2'd1, 1'b0};
        vecs[1] = '{2'b11, 8'h11, 8'h22, 1'b0, 2'b10, 1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 2'd2, 1'b0};
        vecs[2] = '{2'b11, 8'h11, 8'h22, 1'b0, 2'b01, 1'b1, 8'h11, 1'b1, 1'b0, 8'h11, 2'd3, 1'b0};
        vecs[3] = '{2'b11, 8'h11, 8'h22, 1'b0, 2'b10, 1'b1, 8'h22, 1'b1, 1'b1, 8'h22, 2'd3, 1'b0};
        vecs[4] = '{2'b00, 8'h11, 8'h22, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 2'd3, 1'b0};
        vecs[5] = '{2'b00, 8'h11, 8'h22, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 2'd3, 1'b0};
        vecs[6] = '{2'b11, 8'h11, 8'h22, 1'b0, 2'b00, 1'b1, 8'h00, 1'b1, 1'b0, 8'h11, 2'd2, 1'b0};
        vecs[7] = '{2'b11, 8'h11, 8'h22, 1'b0, 2'b00, 1'b1, 8'h00, 1'b1, 1'b1, 8'h22, 2'd1, 1'b0};
        vecs[8] = '{2'b11, 8'h11, 8'h22, 1'b0, 2'b00, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1};
        vecs[9] = '{2'b00, 8'h11, 8'h22, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0};
        // T1: outputs held at 0 while reset is low, even with requests pending
        drive(2'b11, 8'hFF, 8'hEE, 1'b0);
        #12;
        chk("t1_ready", req_ready_o, 0);
        chk("t1_we", sr_we_o, 0);
        chk("t1_ov", out_valid_o, 0);
        chk("t1_fd", flush_done_o, 0);
        chk("t1_occ", occ_o, 0);
        chk("t1_od", out_data_o, 0);
        tick();
        rst_ni = 1'b1;
        // T2: req0 alone streams A0,B1,C2
        drive(2'b01, 8'hA0, 8'h00, 1'b0);
        #1 chk("t2_rdy0", req_ready_o, 2'b01);
        tick();
        chk("t2_occ1", occ_o, 1);
        drive(2'b01, 8'hB1, 8'h00, 1'b0);
        #1 chk("t2_rdy1", req_ready_o, 2'b01);
        tick();
        chk("t2_ov_early", out_valid_o, 0);
        drive(2'b01, 8'hC2, 8'h00, 1'b0);
        #1 chk("t2_rdy2", req_ready_o, 2'b01);
        chk("t2_sd2", sr_data_o, 8'hC2);
        tick();
        chk("t2_ov", out_valid_o, 1);
        chk("t2_id", out_id_o, 0);
        chk("t2_od", out_data_o, 8'hA0);
        chk("t2_occ3", occ_o, 3);
        drive(2'b00, 8'h00, 8'h00, 1'b0);
        tick();
        chk("t2_ov_once", out_valid_o, 0);
        chk("t2_od_hold", out_data_o, 8'hA0);
        // T3 plus drain: table of alternating grants then a flush
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].valid, vecs[i].d0, vecs[i].d1, vecs[i].fl);
            #1;
            chk($sformatf("v%0d_rdy", i), req_ready_o, vecs[i].rdy);
            chk($sformatf("v%0d_we", i), sr_we_o, vecs[i].we);
            chk($sformatf("v%0d_sd", i), sr_data_o, vecs[i].sd);
            tick();
            chk($sformatf("v%0d_ov", i), out_valid_o, vecs[i].ov);
            chk($sformatf("v%0d_oid", i), out_id_o, vecs[i].oid);
            chk($sformatf("v%0d_od", i), out_data_o, vecs[i].od);
            chk($sformatf("v%0d_occ", i), occ_o, vecs[i].occ);
            chk($sformatf("v%0d_fd", i), flush_done_o, vecs[i].fd);
        end
        // T5: flush beats requests; empty line gives immediate done pulse
        drive(2'b11, 8'h33, 8'h44, 1'b1);
        #1 chk("t5_rdy", req_ready_o, 2'b00);
        chk("t5_we", sr_we_o, 0);
        tick();
        chk("t5_fd", flush_done_o, 1);
        chk("t5_occ", occ_o, 0);
        drive(2'b00, 8'h00, 8'h00, 1'b0);
        #1 chk("t5_we_after", sr_we_o, 0);
        tick();
        chk("t5_fd_once", flush_done_o, 0);
        // T4: two words then a full flush
        do_reset();
        drive(2'b01, 8'hA0, 8'h00, 1'b0);
        tick();
        drive(2'b01, 8'hB1, 8'h00, 1'b0);
        tick();
        drive(2'b00, 8'h00, 8'h00, 1'b1);
        #1 chk("t4_we_enter", sr_we_o, 0);
        tick();
        drive(2'b11, 8'h55, 8'h66, 1'b0);
        #1 chk("t4_rdy_b1", req_ready_o, 2'b00);
        chk("t4_we_b1", sr_we_o, 1);
        chk("t4_sd_b1", sr_data_o, 0);
        tick();
        chk("t4_ov_a", out_valid_o, 1);
        chk("t4_id_a", out_id_o, 0);
        chk("t4_od_a", out_data_o, 8'hA0);
        chk("t4_occ_a", occ_o, 2);
        tick();
        chk("t4_ov_b", out_valid_o, 1);
        chk("t4_od_b", out_data_o, 8'hB1);
        chk("t4_occ_b", occ_o, 1);
        chk("t4_fd_early", flush_done_o, 0);
        tick();
        chk("t4_ov_end", out_valid_o, 0);
        chk("t4_occ_end", occ_o, 0);
        chk("t4_fd", flush_done_o, 1);
        drive(2'b01, 8'h77, 8'h00, 1'b0);
        #1 chk("t4_run_rdy", req_ready_o, 2'b01);
        tick();
        chk("t4_fd_once", flush_done_o, 0);
        // T6: reset during the second bubble discards everything
        do_reset();
        drive(2'b01, 8'hA0, 8'h00, 1'b0);
        tick();
        drive(2'b01, 8'hB1, 8'h00, 1'b0);
        tick();
        drive(2'b00, 8'h00, 8'h00, 1'b1);
        tick();
        drive(2'b00, 8'h00, 8'h00, 1'b0);
        tick();
        #2 rst_ni = 1'b0;
        #1;
        chk("t6_we", sr_we_o, 0);
        chk("t6_ov", out_valid_o, 0);
        chk("t6_occ", occ_o, 0);
        chk("t6_od", out_data_o, 0);
        chk("t6_fd", flush_done_o, 0);
        tick();
        tick();
        chk("t6_fd_hold", flush_done_o, 0);
        rst_ni = 1'b1;
        drive(2'b10, 8'h00, 8'h5A, 1'b0);
        #1 chk("t6_rdy", req_ready_o, 2'b10);
        chk("t6_sd", sr_data_o, 8'h5A);
        tick();
        chk("t6_occ1", occ_o, 1);
        chk("t6_fd_none", flush_done_o, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
